// File: rtl/lab4_pkg.sv
// lab4_pkg: shared sizes, state encoding and index mask helper for the permutation generator
//   N_ITEMS/IDX_W  list length and entry width
//   LFSR_W/TAPS    Galois LFSR width and tap mask
//   SEED_DEF       seed after reset and substitute for a zero seed
package lab4_pkg;
    localparam int N_ITEMS = 64;
    localparam int IDX_W = 6;
    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] SEED_DEF = 16'hACE1;
    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} gp_state_t;
    // Smear the top set bit downwards: smallest all-ones value >= i
    function automatic idx_t mask_for(idx_t i);
        idx_t m;
        m = i;
        for (int s = 1; s < IDX_W; s = s * 2) m = m | (m >> s);
        return m;
    endfunction
endpackage

// File: rtl/lfsr_galois.sv
// lfsr_galois: right-shifting Galois LFSR with seed load (zero seed replaced by SEED_DEF)
//   clk, rst (async, active-low), ld/ld_val load, en advance, q current state
module lfsr_galois
    import lab4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [LFSR_W-1:0] ld_val,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= SEED_DEF;
        else if (ld) q <= (ld_val == '0) ? SEED_DEF : ld_val;
        else if (en) q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : '0);
endmodule

// File: rtl/generador_permutacion.sv
// generador_permutacion: Fisher-Yates shuffle of 0..N_ITEMS-1 driven by a Galois LFSR
//   clk, rst (async, active-low)
//   start, seed_ld, seed   request a run / load a seed, honoured in IDLE only
//   busy, done, valid      run in progress / completion pulse / list meaningful
//   lista                  permutation output, one IDX_W entry per slot
module generador_permutacion
    import lab4_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            seed_ld,
    input  logic [LFSR_W-1:0]               seed,
    output logic                            busy,
    output logic                            done,
    output logic                            valid,
    output logic [N_ITEMS-1:0][IDX_W-1:0]   lista
);
    gp_state_t state, state_nx;
    idx_t i, r;
    logic hit;
    logic [LFSR_W-1:0] lfsr;
    lfsr_galois u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .ld     (state == IDLE && seed_ld),
        .ld_val (seed),
        .en     (state == DRAW),
        .q      (lfsr)
    );
    // Masking keeps the rejection rate below one half per step
    always_comb begin
        r = lfsr[IDX_W-1:0] & mask_for(i);
        hit = r <= i;
        state_nx = (state == IDLE) ? (start ? INIT : IDLE) :
                   (state == INIT) ? DRAW :
                   (state == DRAW) ? ((hit && i == idx_t'(1)) ? DONE : DRAW) : IDLE;
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            valid <= 1'b0;
            i <= '0;
            for (int k = 0; k < N_ITEMS; k++) lista[k] <= idx_t'(k);
        end else begin
            state <= state_nx;
            if (state == IDLE && start) valid <= 1'b0;
            if (state == DRAW && state_nx == DONE) valid <= 1'b1;
            if (state == INIT) begin
                for (int k = 0; k < N_ITEMS; k++) lista[k] <= idx_t'(k);
                i <= idx_t'(N_ITEMS - 1);
            end
            // r == i writes the same value to one slot twice, a harmless no-op
            if (state == DRAW && hit) begin
                lista[i] <= lista[r];
                lista[r] <= lista[i];
                i <= i - 1'b1;
            end
        end
endmodule
